// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single data memory
//
// Purpose: serialises accesses from requester 0 (pipeline MEM stage) and
// requester 1 (loader/debug port) onto one data memory. Each transaction is
// IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (one-cycle ready pulse).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mN_req/we/addr/wdata     requester N access request (held until mN_ready)
//   mN_rdata                 requester N registered read data
//   mN_ready                 requester N one-cycle completion pulse
//   mem_read/mem_write       data memory enables (never both high)
//   mem_address/writedata    latched transaction address / write data
//   mem_readdata             data memory read data
//   busy                     high whenever the FSM is not IDLE
//   grant                    index of the requester owning the transaction
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [9:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [9:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic [9:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    output logic        busy,
    output logic        grant
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;     // requester granted most recently
    logic        grant_q, grant_d;
    logic        we_q, we_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        pick;

    // Tie goes to whoever was not served last; otherwise the lone requester.
    always_comb begin
        if (m0_req && m1_req) begin
            pick = ~last_q;
        end else begin
            pick = m1_req;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ACCESS;
                    grant_d = pick;
                    last_d  = pick;
                    we_d    = pick ? m1_we    : m0_we;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (grant_q) begin
                            rdata1_d = mem_readdata;
                        end else begin
                            rdata0_d = mem_readdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;   // makes requester 0 win the first tie
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 10'd0;
            wdata_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // The counter still holds its load value only on the first ACCESS cycle,
    // which is where the single write strobe belongs.
    assign mem_read      = (state_q == ACCESS) && !we_q;
    assign mem_write     = (state_q == ACCESS) && we_q && (cnt_q == CNT_LOAD);
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign m0_ready      = (state_q == DONE) && !grant_q;
    assign m1_ready      = (state_q == DONE) && grant_q;
    assign m0_rdata      = rdata0_q;
    assign m1_rdata      = rdata1_q;
    assign busy          = (state_q != IDLE);
    assign grant         = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (WAIT_CYCLES=2)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        mem_read, mem_write;
    logic [9:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        busy, grant;

    mem_arbiter #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    // Data memory model: unwritten words read 0, except 0x010 preloaded.
    logic [31:0]   tbmem [0:1023];
    logic [1023:0] wr_valid;
    logic          mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            wr_valid <= '0;
        end else if (mem_write) begin
            tbmem[mem_address]    <= mem_writedata;
            wr_valid[mem_address] <= 1'b1;
        end
    end

    assign mem_readdata = !mem_read ? 32'h0 :
                          wr_valid[mem_address] ? tbmem[mem_address] :
                          (mem_address == 10'h010) ? 32'hDEADBEEF : 32'h0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        port;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic [31:0] exp_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic on_ready(input logic p);
        sb_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: ready on port %0d with nothing expected", p);
        end else begin
            e = sbq.pop_front();
            chk("sb_port", 32'(p), 32'(e.port));
            chk("sb_rdata", p ? m1_rdata : m0_rdata, e.rdata);
            exp_rd[p] = e.rdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
    endtask

    task automatic run_txn(input vec_t v);
        int n = 0;
        int rd_cnt = 0;
        int wr_cnt = 0;
        logic done = 1'b0;
        @(negedge clk);
        if (v.port) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        sbq.push_back('{port: v.port, rdata: v.exp_rdata});
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (mem_read) begin
                rd_cnt++;
                chk("rd_addr", 32'(mem_address), 32'(v.addr));
            end
            if (mem_write) begin
                wr_cnt++;
                chk("wr_cycle", 32'(n), 32'd1);
                chk("wr_addr", 32'(mem_address), 32'(v.addr));
                chk("wr_data", mem_writedata, v.wdata);
            end
            if (m0_ready || m1_ready) begin
                chk("latency", 32'(n), 32'd3);
                chk("ready_excl", 32'(m0_ready & m1_ready), 32'd0);
                on_ready(m1_ready);
                m0_req = 1'b0;
                m1_req = 1'b0;
                done = 1'b1;
            end
        end
        chk("txn_done", 32'(done), 32'd1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("rd_cycles", 32'(rd_cnt), v.we ? 32'd0 : 32'd2);
        chk("wr_cycles", 32'(wr_cnt), v.we ? 32'd1 : 32'd0);
        chk("m0_rdata_hold", m0_rdata, exp_rd[0]);
        chk("m1_rdata_hold", m1_rdata, exp_rd[1]);
        @(negedge clk);
        chk("ready_pulse", 32'(m0_ready | m1_ready), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    // Both ports read; readies are expected every 4 cycles in scoreboard order.
    task automatic dual_seq(input int nready, input logic keep0);
        int n = 0;
        int k = 0;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h3FC;
        while (k < nready && n < 60) begin
            @(negedge clk);
            n++;
            chk("dual_ready_excl", 32'(m0_ready & m1_ready), 32'd0);
            if (m0_ready || m1_ready) begin
                chk("dual_latency", 32'(n), 32'(4 * k + 3));
                on_ready(m1_ready);
                if (m1_ready) m1_req = 1'b0;
                else if (!keep0) m0_req = 1'b0;
                k++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("dual_count", 32'(k), 32'(nready));
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        logic done;
        vec_t v;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 10'h010, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 10'h3FC, wdata: 32'hCAFEF00D, exp_rdata: 32'h0};
        vecs[2] = '{port: 1'b1, we: 1'b0, addr: 10'h3FC, wdata: 32'h0,        exp_rdata: 32'hCAFEF00D};
        vecs[3] = '{port: 1'b0, we: 1'b1, addr: 10'h011, wdata: 32'h12345678, exp_rdata: 32'hDEADBEEF};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 10'h011, wdata: 32'h0,        exp_rdata: 32'h12345678};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 10'h000, wdata: 32'h0,        exp_rdata: 32'h0};
        vecs[6] = '{port: 1'b0, we: 1'b0, addr: 10'h010, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};

        rst = 1'b1; mem_clr = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        do_reset();
        mem_clr = 1'b0;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'({m0_ready, m1_ready}), 32'd0);
        chk("rst_mem_en", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Tie after reset: m0 first, then m1; second tie m0 first again.
        do_reset();
        sbq.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
        sbq.push_back('{port: 1'b1, rdata: 32'hCAFEF00D});
        dual_seq(2, 1'b0);
        sbq.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
        sbq.push_back('{port: 1'b1, rdata: 32'hCAFEF00D});
        dual_seq(2, 1'b0);

        // m0 requesting continuously while m1 waits: m0, m1, m0.
        do_reset();
        sbq.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
        sbq.push_back('{port: 1'b1, rdata: 32'hCAFEF00D});
        sbq.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
        dual_seq(3, 1'b1);

        // Inputs change and req drops during ACCESS; latched values must hold.
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h030; m0_wdata = 32'h11112222;
        sbq.push_back('{port: 1'b0, rdata: exp_rd[0]});
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("latch_addr1", 32'(mem_address), 32'h030);
                chk("latch_wdata1", mem_writedata, 32'h11112222);
                m0_req = 1'b0; m0_addr = 10'h3FF; m0_wdata = 32'h0;
            end
            if (n == 2) begin
                chk("latch_addr2", 32'(mem_address), 32'h030);
                chk("latch_wdata2", mem_writedata, 32'h11112222);
            end
            if (m0_ready || m1_ready) begin
                chk("drop_latency", 32'(n), 32'd3);
                on_ready(m1_ready);
                done = 1'b1;
            end
        end
        chk("drop_done", 32'(done), 32'd1);
        v = '{port: 1'b1, we: 1'b0, addr: 10'h030, wdata: 32'h0, exp_rdata: 32'h11112222};
        run_txn(v);
        v = '{port: 1'b1, we: 1'b0, addr: 10'h3FF, wdata: 32'h0, exp_rdata: 32'h0};
        run_txn(v);

        // Reset during write ACCESS, m1 request held through reset.
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h020; m0_wdata = 32'hAAAA5555;
        @(negedge clk);
        chk("abort_wr_issued", 32'(mem_write), 32'd1);
        rst = 1'b1; m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h020;
        @(negedge clk);
        chk("abort_mem_en", 32'({mem_read, mem_write}), 32'd0);
        chk("abort_ready", 32'({m0_ready, m1_ready}), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_grant", 32'(grant), 32'd0);
        @(negedge clk);
        chk("rst_ignores_req", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        sbq.push_back('{port: 1'b1, rdata: 32'hAAAA5555});
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("post_rst_busy", 32'(busy), 32'd1);
                chk("post_rst_grant", 32'(grant), 32'd1);
            end
            chk("post_rst_no_m0_ready", 32'(m0_ready), 32'd0);
            if (m1_ready) begin
                chk("post_rst_latency", 32'(n), 32'd3);
                on_ready(1'b1);
                m1_req = 1'b0;
                done = 1'b1;
            end
        end
        chk("post_rst_done", 32'(done), 32'd1);
        m1_req = 1'b0;
        chk("post_rst_m0_rdata", m0_rdata, 32'h0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
